// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display monitor: active-low segment codes and checker states.
// Segment order is bit6=a .. bit0=g.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Entry d of the table is the code for digit d
    localparam logic [9:0][6:0] SEG_TABLE = {SEG_9, SEG_8, SEG_7, SEG_6, SEG_5,
                                             SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_pattern_decoder.sv
// Combinational 7-segment (active-low) to BCD decoder. Flags blank separately from illegal codes;
// digits at or above the counter modulus N are reported as not legal.
module seg7_pattern_decoder
    import seg7_pkg::*;
#(
    parameter int N = 10
) (
    input  logic [6:0] hex,
    output logic       legal,
    output logic       blank,
    output logic [3:0] digit
);

    logic [9:0] match;

    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_match
            if (gi < N) begin : g_in_range
                assign match[gi] = (hex == SEG_TABLE[gi]);
            end else begin : g_out_of_range
                assign match[gi] = 1'b0;
            end
        end
    endgenerate

    assign legal = |match;
    assign blank = (hex == SEG_BLANK);

    always_comb begin
        digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (match[i]) begin
                digit = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_sequence_checker.sv
// Display-side monitor for the up/down counter: decodes the driven segment pattern and checks that
// each new digit follows the count implied by the counter's direction/hold from the previous edge.
module seg7_sequence_checker
    import seg7_pkg::*;
#(
    parameter int N        = 10,
    parameter int WIDTH    = 7,
    parameter int ERR_W    = 8,
    parameter int LOCK_CNT = 2
) (
    input  logic             Clock_slow,
    input  logic             reset,
    input  logic [WIDTH-1:0] hex_in,
    input  logic             up_down,
    input  logic             pause,
    input  logic             check_en,
    input  logic             err_clr,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             locked,
    output logic             seg_err,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [3:0]       LAST_DIGIT = 4'(N - 1);
    localparam logic [2:0]       LOCK_TGT   = 3'(LOCK_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX    = '1;

    logic       dec_legal;
    logic       dec_blank;
    logic [3:0] dec_digit;

    state_t     state_reg, state_next;
    logic [3:0] ref_reg, ref_next;
    logic [2:0] good_reg, good_next;
    logic       dir_q, pause_q;
    logic [3:0] digit_reg;
    logic       digit_valid_reg;
    logic       locked_reg;
    logic       seg_err_reg, seg_err_next;
    logic       seq_err_reg, seq_err_next;
    logic [ERR_W-1:0] err_count_reg, err_count_next;
    logic [3:0] exp_digit;
    logic [2:0] good_inc;
    logic       in_seq;
    logic       any_err;

    seg7_pattern_decoder #(.N(N)) u_decoder (
        .hex   (hex_in[6:0]),
        .legal (dec_legal),
        .blank (dec_blank),
        .digit (dec_digit)
    );

    // The counter moved on the previous edge using the previous up_down/pause, hence dir_q/pause_q
    always_comb begin
        exp_digit = ref_reg;
        if (!pause_q) begin
            if (dir_q) begin
                exp_digit = (ref_reg == LAST_DIGIT) ? 4'd0 : ref_reg + 4'd1;
            end else begin
                exp_digit = (ref_reg == 4'd0) ? LAST_DIGIT : ref_reg - 4'd1;
            end
        end
    end

    assign in_seq   = (dec_digit == exp_digit);
    assign good_inc = good_reg + 3'd1;

    always_comb begin
        state_next   = state_reg;
        ref_next     = ref_reg;
        good_next    = good_reg;
        seg_err_next = 1'b0;
        seq_err_next = 1'b0;
        if (!check_en) begin
            state_next = HUNT;
            good_next  = 3'd0;
        end else begin
            case (state_reg)
                HUNT: begin
                    if (dec_legal) begin
                        ref_next   = dec_digit;
                        good_next  = 3'd0;
                        state_next = ACQUIRE;
                    end else if (!dec_blank) begin
                        seg_err_next = 1'b1;
                    end
                end
                ACQUIRE: begin
                    if (dec_legal) begin
                        ref_next = dec_digit;
                        if (in_seq) begin
                            good_next = good_inc;
                            if (good_inc >= LOCK_TGT) begin
                                state_next = LOCKED;
                            end
                        end else begin
                            good_next = 3'd0;
                        end
                    end else begin
                        seg_err_next = !dec_blank;
                        state_next   = HUNT;
                    end
                end
                LOCKED: begin
                    if (dec_legal) begin
                        ref_next = dec_digit;
                        if (!in_seq) begin
                            seq_err_next = 1'b1;
                            good_next    = 3'd0;
                            state_next   = ACQUIRE;
                        end
                    end else begin
                        seg_err_next = !dec_blank;
                        state_next   = HUNT;
                    end
                end
                default: begin
                    state_next = HUNT;
                    good_next  = 3'd0;
                end
            endcase
        end
    end

    assign any_err = seg_err_next | seq_err_next;

    // A clear coinciding with an error leaves that error counted
    always_comb begin
        err_count_next = err_count_reg;
        if (err_clr) begin
            err_count_next = any_err ? ERR_W'(1) : '0;
        end else if (any_err && (err_count_reg != ERR_MAX)) begin
            err_count_next = err_count_reg + ERR_W'(1);
        end
    end

    always_ff @(posedge Clock_slow or negedge reset) begin
        if (!reset) begin
            state_reg       <= HUNT;
            ref_reg         <= 4'd0;
            good_reg        <= 3'd0;
            dir_q           <= 1'b1;
            pause_q         <= 1'b0;
            digit_reg       <= 4'd0;
            digit_valid_reg <= 1'b0;
            locked_reg      <= 1'b0;
            seg_err_reg     <= 1'b0;
            seq_err_reg     <= 1'b0;
            err_count_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            ref_reg         <= ref_next;
            good_reg        <= good_next;
            dir_q           <= up_down;
            pause_q         <= pause;
            if (dec_legal) begin
                digit_reg <= dec_digit;
            end
            digit_valid_reg <= dec_legal;
            locked_reg      <= (state_next == LOCKED);
            seg_err_reg     <= seg_err_next;
            seq_err_reg     <= seq_err_next;
            err_count_reg   <= err_count_next;
        end
    end

    assign digit       = digit_reg;
    assign digit_valid = digit_valid_reg;
    assign locked      = locked_reg;
    assign seg_err     = seg_err_reg;
    assign seq_err     = seq_err_reg;
    assign err_count   = err_count_reg;

endmodule

// File: tb/tb_seg7_sequence_checker.sv
// Directed bench for seg7_sequence_checker: locking, wrap in both directions, sequence/segment errors,
// pause handling, error counter saturation/clear, check_en gating and asynchronous reset.
module tb_seg7_sequence_checker;

    logic       Clock_slow;
    logic       reset;
    logic [6:0] hex_in;
    logic       up_down;
    logic       pause;
    logic       check_en;
    logic       err_clr;
    logic [3:0] digit;
    logic       digit_valid;
    logic       locked;
    logic       seg_err;
    logic       seq_err;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] codes [10];
    localparam logic [6:0] BAD   = 7'b1010101;
    localparam logic [6:0] BLANK = 7'b1111111;

    seg7_sequence_checker dut (
        .Clock_slow  (Clock_slow),
        .reset       (reset),
        .hex_in      (hex_in),
        .up_down     (up_down),
        .pause       (pause),
        .check_en    (check_en),
        .err_clr     (err_clr),
        .digit       (digit),
        .digit_valid (digit_valid),
        .locked      (locked),
        .seg_err     (seg_err),
        .seq_err     (seq_err),
        .err_count   (err_count)
    );

    initial Clock_slow = 1'b0;
    always #5 Clock_slow = ~Clock_slow;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_all(input string tag, input int d, input int dv, input int lk,
                           input int sg, input int sq, input int ec);
        chk({tag, ".digit"},       32'(digit),       32'(d));
        chk({tag, ".digit_valid"}, 32'(digit_valid), 32'(dv));
        chk({tag, ".locked"},      32'(locked),      32'(lk));
        chk({tag, ".seg_err"},     32'(seg_err),     32'(sg));
        chk({tag, ".seq_err"},     32'(seq_err),     32'(sq));
        chk({tag, ".err_count"},   32'(err_count),   32'(ec));
    endtask

    // Apply one sample, clock it, then look at the outputs 1 time unit after the edge
    task automatic step(input logic [6:0] hex, input logic ud, input logic p);
        hex_in  = hex;
        up_down = ud;
        pause   = p;
        @(posedge Clock_slow);
        #1;
    endtask

    initial begin
        codes[0] = 7'b0000001; codes[1] = 7'b1001111; codes[2] = 7'b0010010;
        codes[3] = 7'b0000110; codes[4] = 7'b1001100; codes[5] = 7'b0100100;
        codes[6] = 7'b0100000; codes[7] = 7'b0001111; codes[8] = 7'b0000000;
        codes[9] = 7'b0000100;

        reset    = 1'b0;
        hex_in   = BLANK;
        up_down  = 1'b1;
        pause    = 1'b0;
        check_en = 1'b1;
        err_clr  = 1'b0;
        repeat (2) @(posedge Clock_slow);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        #3 reset = 1'b1;

        // Acquire and lock counting up 0,1,2,3
        step(codes[0], 1, 0); chk_all("acq0", 0, 1, 0, 0, 0, 0);
        step(codes[1], 1, 0); chk_all("acq1", 1, 1, 0, 0, 0, 0);
        step(codes[2], 1, 0); chk_all("acq2", 2, 1, 1, 0, 0, 0);
        step(codes[3], 1, 0); chk_all("acq3", 3, 1, 1, 0, 0, 0);

        // Up through 9 -> 0 wrap, then turn down 0 -> 9 -> 8
        for (int i = 4; i <= 9; i++) begin
            step(codes[i], 1, 0);
        end
        chk_all("up9", 9, 1, 1, 0, 0, 0);
        step(codes[0], 0, 0); chk_all("wrap_up", 0, 1, 1, 0, 0, 0);
        step(codes[9], 0, 0); chk_all("wrap_dn", 9, 1, 1, 0, 0, 0);
        step(codes[8], 0, 0); chk_all("down8", 8, 1, 1, 0, 0, 0);

        // Down to 4, then jump to 6 while counting up -> sequence error, relock on 7,8
        step(codes[7], 0, 0);
        step(codes[6], 0, 0);
        step(codes[5], 0, 0);
        step(codes[4], 1, 0); chk_all("down4", 4, 1, 1, 0, 0, 0);
        step(codes[6], 1, 0); chk_all("jump6", 6, 1, 0, 0, 1, 1);
        step(codes[7], 1, 0); chk_all("reacq7", 7, 1, 0, 0, 0, 1);
        step(codes[8], 1, 0); chk_all("relock8", 8, 1, 1, 0, 0, 1);

        // Illegal pattern while locked, then blank
        step(BAD, 1, 0);   chk_all("illegal", 8, 0, 0, 1, 0, 2);
        step(BLANK, 1, 0); chk_all("blank", 8, 0, 0, 0, 0, 2);

        // Pause handling: lock at 5 with pause raised, hold accepted, then 5->6 rejected
        step(codes[3], 1, 0); chk_all("p_acq3", 3, 1, 0, 0, 0, 2);
        step(codes[4], 1, 0); chk_all("p_acq4", 4, 1, 0, 0, 0, 2);
        step(codes[5], 1, 1); chk_all("p_lock5", 5, 1, 1, 0, 0, 2);
        step(codes[5], 1, 1); chk_all("p_hold5", 5, 1, 1, 0, 0, 2);
        step(codes[6], 1, 1); chk_all("p_move6", 6, 1, 0, 0, 1, 3);

        // Drive the error counter to saturation with back-to-back illegal samples
        for (int i = 0; i < 252; i++) begin
            step(BAD, 1, 0);
        end
        chk_all("sat_reach", 6, 0, 0, 1, 0, 255);
        step(BAD, 1, 0); chk_all("sat_hold", 6, 0, 0, 1, 0, 255);

        err_clr = 1'b1;
        step(BAD, 1, 0); chk_all("clr_with_err", 6, 0, 0, 1, 0, 1);
        err_clr = 1'b0;

        // Checking disabled: illegal pattern is silent and the count holds
        check_en = 1'b0;
        step(BAD, 1, 0); chk_all("chk_dis", 6, 0, 0, 0, 0, 1);
        check_en = 1'b1;

        // Lock again, then assert reset between edges
        step(codes[1], 1, 0);
        step(codes[2], 1, 0);
        step(codes[3], 1, 0); chk_all("pre_rst", 3, 1, 1, 0, 0, 1);
        #2 reset = 1'b0;
        #1 chk_all("async_rst", 0, 0, 0, 0, 0, 0);
        @(posedge Clock_slow);
        #1 chk_all("rst_held", 0, 0, 0, 0, 0, 0);
        #3 reset = 1'b1;
        step(codes[7], 1, 0); chk_all("post_rst", 7, 1, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
